// File: rtl/a2d_pkg.sv
// Shared definitions for the ADC128S-style round-robin scanner.
// Holds result/command widths, the command header, the FSM state
// encoding and a helper that builds the SPI command word for a channel.
package a2d_pkg;

  localparam int unsigned A2D_RES_W  = 12;
  localparam int unsigned A2D_MAX_CH = 8;
  localparam int unsigned A2D_CH_W   = 3;
  localparam int unsigned A2D_CMD_W  = 16;
  localparam int unsigned A2D_ST_W   = 3;

  localparam logic [1:0] A2D_CMD_HDR = 2'b00;

  // Scanner FSM state encoding (WAIT1 is reserved and decodes to IDLE)
  typedef logic [A2D_ST_W-1:0] a2d_state_t;
  localparam a2d_state_t ST_IDLE  = 3'd0;
  localparam a2d_state_t ST_TX1   = 3'd1;
  localparam a2d_state_t ST_WAIT1 = 3'd2;
  localparam a2d_state_t ST_GAP   = 3'd3;
  localparam a2d_state_t ST_TX2   = 3'd4;
  localparam a2d_state_t ST_STORE = 3'd5;

  // SPI command word: header, channel address, 11 don't-care zero bits
  function automatic logic [A2D_CMD_W-1:0] a2d_cmd(input logic [A2D_CH_W-1:0] ch);
    return {A2D_CMD_HDR, ch, 11'h000};
  endfunction

endpackage

// File: rtl/a2d_period_tmr.sv
// Scan period timer.
// Counts 0..PERIOD-1 while en is high (held at 0 while low) and emits a
// one-cycle start pulse on the first cycle en is seen high and on every
// counter wrap thereafter, so successive starts are PERIOD clocks apart.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   en        - scan enable level
//   start     - registered one-cycle scan-start pulse
module a2d_period_tmr
  import a2d_pkg::*;
#(
  parameter int unsigned PERIOD = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic start
);

  localparam int unsigned     CNT_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt;
  logic             en_q;
  logic             rise_c;
  logic             wrap_c;

  assign rise_c = en & ~en_q;
  assign wrap_c = en & en_q & (cnt == CNT_MAX);

  // The rising edge restarts the count at 0 so the next wrap lands PERIOD later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      en_q  <= 1'b0;
      start <= 1'b0;
    end else begin
      en_q  <= en;
      start <= rise_c | wrap_c;
      if (en && en_q) begin
        cnt <= wrap_c ? '0 : cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/a2d_scan.sv
// Round-robin ADC scanner driving an SPI master (wrt/cmd) and consuming its
// done/rd_data to maintain a bank of 12-bit conversion results.
// Each channel takes two SPI transactions: the first returns the previous
// conversion and is discarded, the second returns this channel's result.
// Optional feature macro: A2D_AVG_EN - store (old + new) >> 1 instead of new.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   en         - scan enable level
//   scan_done  - one-cycle pulse after the last channel is stored
//   busy       - high from scan start until scan_done
//   rd_ch      - result select
//   rd_res     - combinational result bank read (0 for rd_ch >= NUM_CH)
//   wrt        - one-cycle SPI transaction start
//   cmd        - SPI command word, held from wrt until the matching done
//   done       - SPI transaction complete (rising edge used)
//   rd_data    - SPI receive data, valid when done rises
module a2d_scan
  import a2d_pkg::*;
#(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned PERIOD = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic                 scan_done,
  output logic                 busy,
  input  logic [A2D_CH_W-1:0]  rd_ch,
  output logic [A2D_RES_W-1:0] rd_res,
  output logic                 wrt,
  output logic [A2D_CMD_W-1:0] cmd,
  input  logic                 done,
  input  logic [A2D_CMD_W-1:0] rd_data
);

  localparam logic [A2D_CH_W-1:0] LAST_CH = A2D_CH_W'(NUM_CH - 1);

  a2d_state_t           state, state_nxt;
  logic [A2D_CH_W-1:0]  ch, ch_nxt;
  logic [A2D_CH_W-1:0]  ch_inc_c;
  logic                 wrt_nxt;
  logic [A2D_CMD_W-1:0] cmd_nxt;
  logic                 scan_done_nxt;
  logic                 busy_nxt;
  logic                 scan_start;
  logic                 done_q;
  logic                 done_rise_c;
  logic                 cap_c;
  logic                 bank_we_c;
  logic [A2D_RES_W-1:0] sample;
  logic [A2D_RES_W-1:0] new_res_c;
  logic [A2D_RES_W-1:0] bank [A2D_MAX_CH];
  logic                 unused_rd_hi;

  a2d_period_tmr #(
    .PERIOD (PERIOD)
  ) u_tmr (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .start (scan_start)
  );

  // Upper receive bits carry no conversion data
  assign unused_rd_hi = ^rd_data[A2D_CMD_W-1:A2D_RES_W];

  // Only a fresh rising edge of done counts; a level held over is ignored
  assign done_rise_c = done & ~done_q;
  assign ch_inc_c    = ch + A2D_CH_W'(1);

  // Next-state and next-output decode
  always_comb begin
    state_nxt     = state;
    ch_nxt        = ch;
    wrt_nxt       = 1'b0;
    cmd_nxt       = cmd;
    scan_done_nxt = 1'b0;
    busy_nxt      = busy;
    cap_c         = 1'b0;
    bank_we_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (scan_start) begin
          state_nxt = ST_TX1;
          ch_nxt    = '0;
          wrt_nxt   = 1'b1;
          cmd_nxt   = a2d_cmd(A2D_CH_W'(0));
          busy_nxt  = 1'b1;
        end
      end
      ST_TX1: begin
        if (done_rise_c) begin
          state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        wrt_nxt   = 1'b1;
        state_nxt = ST_TX2;
      end
      ST_TX2: begin
        if (done_rise_c) begin
          cap_c     = 1'b1;
          state_nxt = ST_STORE;
        end
      end
      ST_STORE: begin
        bank_we_c = 1'b1;
        if (ch == LAST_CH) begin
          scan_done_nxt = 1'b1;
          busy_nxt      = 1'b0;
          ch_nxt        = '0;
          state_nxt     = ST_IDLE;
        end else begin
          ch_nxt    = ch_inc_c;
          wrt_nxt   = 1'b1;
          cmd_nxt   = a2d_cmd(ch_inc_c);
          state_nxt = ST_TX1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, handshake and capture registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ch        <= '0;
      wrt       <= 1'b0;
      cmd       <= '0;
      scan_done <= 1'b0;
      busy      <= 1'b0;
      done_q    <= 1'b0;
      sample    <= '0;
    end else begin
      state     <= state_nxt;
      ch        <= ch_nxt;
      wrt       <= wrt_nxt;
      cmd       <= cmd_nxt;
      scan_done <= scan_done_nxt;
      busy      <= busy_nxt;
      done_q    <= done;
      if (cap_c) begin
        sample <= rd_data[A2D_RES_W-1:0];
      end
    end
  end

`ifdef A2D_AVG_EN
  // Running average with the stored value; 13-bit sum, truncated
  logic [A2D_RES_W:0] sum_c;
  assign sum_c     = {1'b0, bank[ch]} + {1'b0, sample};
  assign new_res_c = A2D_RES_W'(sum_c >> 1);
`else
  assign new_res_c = sample;
`endif

  // Result bank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < A2D_MAX_CH; i++) begin
        bank[i] <= '0;
      end
    end else if (bank_we_c) begin
      bank[ch] <= new_res_c;
    end
  end

  assign rd_res = (32'(rd_ch) < NUM_CH) ? bank[rd_ch] : '0;

endmodule
